button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/screen_pkg.sv | 20 ++
 rtl/debounce_one.sv | 58 +++++
 rtl/button_conditioner.sv | 124 ++++++++++++
 tb/tb_button_conditioner.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared constants for the screen controller: button indices, default
// timing for the button conditioner, and the auto-repeat state encoding.
package screen_pkg;

   localparam int unsigned BTN_LEFT   = 0;
   localparam int unsigned BTN_MIDDLE = 1;
   localparam int unsigned BTN_RIGHT  = 2;

   // Defaults assume a 74.25 MHz pixel clock
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 74_250;      // 1 ms
   localparam int unsigned DEF_HOLD_CYCLES     = 37_125_000;  // 0.5 s
   localparam int unsigned DEF_REPEAT_CYCLES   = 7_425_000;   // 0.1 s

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_HOLD   = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_t;

endpackage

// File: rtl/debounce_one.sv
// One push-button: 2-flop synchroniser, stability counter, debounced
// level and a single-cycle pulse on each debounced rise.
module debounce_one
   import screen_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic clk_in,
   input  logic rst_in,
   input  logic raw_in,
   output logic level_out,
   output logic level_next_out,
   output logic rise_out
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

   logic          sync1_q;
   logic          sync2_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          level_d;

   // Count consecutive mismatched cycles; toggle the level once the
   // mismatch has lasted DEBOUNCE_CYCLES and restart on any agreement
   always_comb begin
      cnt_d   = '0;
      level_d = level_out;
      if (sync2_q != level_out) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1))
            level_d = ~level_out;
         else
            cnt_d = cnt_q + CW'(1);
      end
   end

   // Next level is exported so the owner can act in the same edge the
   // level changes
   assign level_next_out = level_d;

   // Synchroniser, counter, level and rise pulse registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         cnt_q     <= '0;
         level_out <= 1'b0;
         rise_out  <= 1'b0;
      end else begin
         sync1_q   <= raw_in;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         level_out <= level_d;
         rise_out  <= level_d & ~level_out;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Debounces the three push-buttons and turns left/right into step pulses
// with hold-to-repeat; middle gives a single click per press.
module button_conditioner
   import screen_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
)(
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [2:0] btn_raw_in,
   output logic       left_out,
   output logic       middle_out,
   output logic       right_out,
   output logic       left_step_out,
   output logic       right_step_out,
   output logic       middle_click_out
);

   localparam int unsigned TW = $clog2(HOLD_CYCLES) + 1;

   logic [2:0] lvl;
   logic [2:0] lvl_nxt;
   logic [2:0] rise;

   for (genvar g = 0; g < 3; g++) begin : g_deb
      debounce_one #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk_in        (clk_in),
         .rst_in        (rst_in),
         .raw_in        (btn_raw_in[g]),
         .level_out     (lvl[g]),
         .level_next_out(lvl_nxt[g]),
         .rise_out      (rise[g])
      );
   end

   // Left/right press pulses come from the repeat FSMs, which fold the
   // press into their own registered step output
   logic unused_rise;
   assign unused_rise = rise[BTN_LEFT] ^ rise[BTN_RIGHT];

   // Repeat side index: 0 = left, 1 = right
   logic [1:0]    s_lvl;
   logic [1:0]    s_nxt;
   logic          both_held;
   rpt_state_t    st_q  [2];
   rpt_state_t    st_d  [2];
   logic [TW-1:0] tmr_q [2];
   logic [TW-1:0] tmr_d [2];
   logic [1:0]    step_q;
   logic [1:0]    step_d;

   assign s_lvl     = {lvl[BTN_RIGHT], lvl[BTN_LEFT]};
   assign s_nxt     = {lvl_nxt[BTN_RIGHT], lvl_nxt[BTN_LEFT]};
   assign both_held = s_nxt[0] & s_nxt[1];

   // Repeat FSMs; transitions use the next debounced level so the press
   // pulse lands on the same edge the level rises
   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         st_d[i]   = st_q[i];
         tmr_d[i]  = '0;
         step_d[i] = 1'b0;
         if (s_lvl[i] & ~s_nxt[i]) begin
            st_d[i] = RPT_IDLE;
         end else if (both_held) begin
            st_d[i]   = RPT_IDLE;
            step_d[i] = s_nxt[i] & ~s_lvl[i];
         end else begin
            case (st_q[i])
               RPT_IDLE: begin
                  if (s_nxt[i] & ~s_lvl[i]) begin
                     st_d[i]   = RPT_HOLD;
                     step_d[i] = 1'b1;
                  end
               end
               RPT_HOLD: begin
                  if (tmr_q[i] == TW'(HOLD_CYCLES - 1)) begin
                     st_d[i]   = RPT_REPEAT;
                     step_d[i] = 1'b1;
                  end else begin
                     tmr_d[i] = tmr_q[i] + TW'(1);
                  end
               end
               RPT_REPEAT: begin
                  if (tmr_q[i] == TW'(REPEAT_CYCLES - 1))
                     step_d[i] = 1'b1;
                  else
                     tmr_d[i] = tmr_q[i] + TW'(1);
               end
               default: st_d[i] = RPT_IDLE;
            endcase
         end
      end
   end

   // FSM state, timers and step pulse registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int unsigned i = 0; i < 2; i++) begin
            st_q[i]  <= RPT_IDLE;
            tmr_q[i] <= '0;
         end
         step_q <= '0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            st_q[i]  <= st_d[i];
            tmr_q[i] <= tmr_d[i];
         end
         step_q <= step_d;
      end
   end

   assign left_out         = lvl[BTN_LEFT];
   assign middle_out       = lvl[BTN_MIDDLE];
   assign right_out        = lvl[BTN_RIGHT];
   assign left_step_out    = step_q[0];
   assign right_step_out   = step_q[1];
   assign middle_click_out = rise[BTN_MIDDLE];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short timing parameters.
// Event mask bits: 0 left step, 1 right step, 2 middle click,
// 3 left level change, 4 middle level change, 5 right level change.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] btn;
   logic       left_out, middle_out, right_out;
   logic       left_step_out, right_step_out, middle_click_out;

   button_conditioner #(
      .DEBOUNCE_CYCLES(8),
      .HOLD_CYCLES    (40),
      .REPEAT_CYCLES  (10)
   ) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .btn_raw_in      (btn),
      .left_out        (left_out),
      .middle_out      (middle_out),
      .right_out       (right_out),
      .left_step_out   (left_step_out),
      .right_step_out  (right_step_out),
      .middle_click_out(middle_click_out)
   );

   always #5 clk = ~clk;

   int unsigned edge_no = 0;
   always @(posedge clk) edge_no <= edge_no + 1;

   typedef struct packed {
      int unsigned edge_no;
      logic [5:0]  mask;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned base;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   localparam logic [5:0] EV_SL = 6'b000001;
   localparam logic [5:0] EV_SR = 6'b000010;
   localparam logic [5:0] EV_CK = 6'b000100;
   localparam logic [5:0] EV_LL = 6'b001000;
   localparam logic [5:0] EV_LM = 6'b010000;
   localparam logic [5:0] EV_LR = 6'b100000;

   task automatic start();
      @(negedge clk);
      base = edge_no;
   endtask

   task automatic hold(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_ev(input int unsigned rel, input logic [5:0] mask);
      exp_t e;
      e.edge_no = base + rel;
      e.mask    = mask;
      exp_q.push_back(e);
   endtask

   initial begin
      rst = 1'b1;
      btn = 3'b000;
      fork
         // Monitor: every output activity pops and checks the next expectation
         begin : monitor
            logic [2:0] prev_lvl;
            logic [5:0] act;
            exp_t       e;
            prev_lvl = 3'b000;
            forever begin
               @(posedge clk);
               #1;
               act = {right_out ^ prev_lvl[2], middle_out ^ prev_lvl[1],
                      left_out ^ prev_lvl[0], middle_click_out,
                      right_step_out, left_step_out};
               prev_lvl = {right_out, middle_out, left_out};
               if (act != 6'b0) begin
                  n_checks++;
                  if (exp_q.size() == 0) begin
                     n_fail++;
                     $display("FAIL unexpected_event: edge %0d mask %b, required none",
                              edge_no - base, act);
                  end else begin
                     e = exp_q.pop_front();
                     if (e.edge_no != edge_no || e.mask != act) begin
                        n_fail++;
                        $display("FAIL event: edge %0d mask %b, required edge %0d mask %b",
                                 edge_no - base, act, e.edge_no - base, e.mask);
                     end
                  end
               end
            end
         end
         begin : stimulus
            // Reset state
            hold(3);
            n_checks++;
            if ({left_out, middle_out, right_out, left_step_out, right_step_out,
                 middle_click_out} != 6'b0) begin
               n_fail++;
               $display("FAIL reset_state: got %b required 000000",
                        {left_out, middle_out, right_out, left_step_out,
                         right_step_out, middle_click_out});
            end
            rst = 1'b0;
            hold(5);

            // Clean left press, 100 cycles
            start();
            expect_ev(10, EV_LL | EV_SL);
            for (int unsigned k = 50; k <= 100; k += 10) expect_ev(k, EV_SL);
            expect_ev(110, EV_LL);
            btn = 3'b001;
            hold(100);
            btn = 3'b000;
            hold(20);
            check_empty("clean_press");

            // Middle bounce every 3 cycles for 30 cycles, then held
            start();
            expect_ev(40, EV_LM | EV_CK);
            expect_ev(100, EV_LM);
            for (int unsigned i = 0; i < 10; i++) begin
               btn = (i % 2 == 0) ? 3'b010 : 3'b000;
               hold(3);
            end
            btn = 3'b010;
            hold(60);
            btn = 3'b000;
            hold(20);
            check_empty("bounce");

            // Right auto-repeat, 200 cycles
            start();
            expect_ev(10, EV_LR | EV_SR);
            for (int unsigned k = 50; k <= 200; k += 10) expect_ev(k, EV_SR);
            expect_ev(210, EV_LR);
            btn = 3'b100;
            hold(200);
            btn = 3'b000;
            hold(20);
            check_empty("auto_repeat");

            // Left and right together: press pulses only
            start();
            expect_ev(10, EV_LL | EV_LR | EV_SL | EV_SR);
            expect_ev(160, EV_LL | EV_LR);
            btn = 3'b101;
            hold(150);
            btn = 3'b000;
            hold(20);
            check_empty("both_held");

            // Glitches shorter than the debounce window
            start();
            btn = 3'b001;
            hold(5);
            btn = 3'b000;
            hold(2);
            btn = 3'b001;
            hold(5);
            btn = 3'b000;
            hold(20);
            check_empty("glitch");

            // Reset during repeat with right still held
            start();
            expect_ev(10, EV_LR | EV_SR);
            expect_ev(50, EV_SR);
            expect_ev(60, EV_SR);
            expect_ev(66, EV_LR);
            expect_ev(77, EV_LR | EV_SR);
            for (int unsigned k = 117; k <= 147; k += 10) expect_ev(k, EV_SR);
            expect_ev(150, EV_LR);
            btn = 3'b100;
            hold(65);
            #2 rst = 1'b1;
            #1;
            n_checks++;
            if ({left_out, middle_out, right_out, left_step_out, right_step_out,
                 middle_click_out} != 6'b0) begin
               n_fail++;
               $display("FAIL async_reset: got %b required 000000",
                        {left_out, middle_out, right_out, left_step_out,
                         right_step_out, middle_click_out});
            end
            hold(2);
            rst = 1'b0;
            hold(73);
            btn = 3'b000;
            hold(20);
            check_empty("reset_mid_repeat");

            $display("End of test - %0d assertions evaluated, %0d failures",
                     n_checks, n_fail);
            $finish;
         end
      join
   end

   task automatic check_empty(input string name);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s missing_events: %0d left, next edge %0d mask %b, required 0 left",
                  name, exp_q.size(), exp_q[0].edge_no - base, exp_q[0].mask);
         exp_q.delete();
      end
   endtask

endmodule
